// File: rtl/sisp_out_collector.sv
// Output collector: buffers 64-bit SISP result words in a FIFO and drains them as 4 x 16-bit beats, LSB first.
// Optional build macro SISP_OUT_PARITY_EN adds per-slice parity storage, out_parity_o and sticky parity_err_o.
module sisp_out_collector #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned AFULL_MARGIN = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [63:0]              DataOut_i,
    input  logic                     DataOutReady_i,
    output logic                     seg_stall_o,
    output logic [15:0]              out_data_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic                     out_last_o,
    output logic                     overflow_o,
    output logic [$clog2(DEPTH):0]   word_count_o
`ifdef SISP_OUT_PARITY_EN
    ,
    output logic                     out_parity_o,
    output logic                     parity_err_o
`endif
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam int unsigned CW        = AW + 1;
    localparam int unsigned STALL_LVL = (AFULL_MARGIN >= DEPTH) ? 0 : DEPTH - AFULL_MARGIN;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t          state, state_next;
    logic [1:0]      beat, beat_next;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count, count_next;
    logic            overflow;
    logic [63:0]     data_mem [DEPTH];
    logic [63:0]     head;
    logic [15:0]     slice;
    logic            full, push, drop, beat_done, pop;

    // Fullness is judged before any same-edge pop, so a strobe into a full FIFO always drops.
    assign full      = (count == CW'(DEPTH));
    assign push      = DataOutReady_i && !full;
    assign drop      = DataOutReady_i && full;
    assign beat_done = (state == SEND) && out_ready_i;
    assign pop       = beat_done && (beat == 2'd3);
    assign head      = data_mem[rd_ptr];
    assign slice     = head[{beat, 4'b0000} +: 16];

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + CW'(1);
            2'b01:   count_next = count - CW'(1);
            default: count_next = count;
        endcase
    end

    // Leaving SEND looks at the post-edge count so a push landing on the pop edge stays gap-free.
    always_comb begin
        state_next = state;
        beat_next  = beat;
        case (state)
            IDLE: begin
                beat_next = '0;
                if (count != '0) state_next = SEND;
            end
            SEND: begin
                if (out_ready_i) begin
                    beat_next = beat + 2'd1;
                    if ((beat == 2'd3) && (count_next == '0)) state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
                beat_next  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            beat     <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            state <= state_next;
            beat  <= beat_next;
            count <= count_next;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (drop) overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) data_mem[wr_ptr] <= DataOut_i;
    end

    assign out_valid_o  = (state == SEND);
    assign out_data_o   = (state == SEND) ? slice : '0;
    assign out_last_o   = (state == SEND) && (beat == 2'd3);
    assign overflow_o   = overflow;
    assign word_count_o = count;
    assign seg_stall_o  = (count >= CW'(STALL_LVL));

`ifdef SISP_OUT_PARITY_EN
    logic [3:0] par_mem [DEPTH];
    logic       par_err;

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            par_mem[wr_ptr] <= {^DataOut_i[63:48], ^DataOut_i[47:32],
                                ^DataOut_i[31:16], ^DataOut_i[15:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            par_err <= 1'b0;
        end else if (beat_done && ((^slice) != par_mem[rd_ptr][beat])) begin
            par_err <= 1'b1;
        end
    end

    assign out_parity_o = ^out_data_o;
    assign parity_err_o = par_err;
`endif

endmodule

// File: tb/tb_sisp_out_collector.sv
// Directed bench for sisp_out_collector: reset, serialization, backpressure, fill/overflow, wrap-around, mid-word reset.
module tb_sisp_out_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] DataOut_i;
    logic        DataOutReady_i;
    logic        seg_stall_o;
    logic [15:0] out_data_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_last_o;
    logic        overflow_o;
    logic [3:0]  word_count_o;
`ifdef SISP_OUT_PARITY_EN
    logic        out_parity_o;
    logic        parity_err_o;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    sisp_out_collector #(.DEPTH(8), .AFULL_MARGIN(2)) dut (
        .clk            (clk),
        .reset          (reset),
        .DataOut_i      (DataOut_i),
        .DataOutReady_i (DataOutReady_i),
        .seg_stall_o    (seg_stall_o),
        .out_data_o     (out_data_o),
        .out_valid_o    (out_valid_o),
        .out_ready_i    (out_ready_i),
        .out_last_o     (out_last_o),
        .overflow_o     (overflow_o),
        .word_count_o   (word_count_o)
`ifdef SISP_OUT_PARITY_EN
        ,
        .out_parity_o   (out_parity_o),
        .parity_err_o   (parity_err_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $display("FAIL %s: observed %h, expected %h", tag, obs, exp);
            $error("%s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] sl(input logic [63:0] w, input int unsigned b);
        return w[16*b +: 16];
    endfunction

    function automatic logic [63:0] fill_word(input int unsigned k);
        return 64'hF0F0_0000_0000_0000 | (64'(k) * 64'h0001_0001_0001_0001);
    endfunction

    // Checks the beat currently presented on the output bus.
    task automatic chk_beat(input string tag, input logic [63:0] w, input int unsigned b);
        chk({tag, "_valid"}, 64'(out_valid_o), 64'd1);
        chk({tag, "_data"},  64'(out_data_o),  64'(sl(w, b)));
        chk({tag, "_last"},  64'(out_last_o),  64'(b == 3));
`ifdef SISP_OUT_PARITY_EN
        chk({tag, "_par"},   64'(out_parity_o), 64'(^sl(w, b)));
`endif
    endtask

    logic [63:0] w1;
    logic [63:0] w2;
    logic [63:0] wz;
    logic [6:0]  pat;
    int unsigned b;

    initial begin
        reset          = 1'b1;
        DataOut_i      = '0;
        DataOutReady_i = 1'b0;
        out_ready_i    = 1'b0;
        tick();
        tick();
        chk("rst_valid", 64'(out_valid_o),  64'd0);
        chk("rst_last",  64'(out_last_o),   64'd0);
        chk("rst_data",  64'(out_data_o),   64'd0);
        chk("rst_ovf",   64'(overflow_o),   64'd0);
        chk("rst_stall", 64'(seg_stall_o),  64'd0);
        chk("rst_count", 64'(word_count_o), 64'd0);
        reset = 1'b0;
        tick();

        // Single word, ready held high: beats CDEF, 89AB, 4567, 0123 on consecutive cycles.
        w1             = 64'h0123_4567_89AB_CDEF;
        DataOut_i      = w1;
        DataOutReady_i = 1'b1;
        out_ready_i    = 1'b1;
        tick();
        DataOutReady_i = 1'b0;
        chk("single_cnt1",   64'(word_count_o), 64'd1);
        chk("single_lat0",   64'(out_valid_o),  64'd0);
        tick();
        for (int unsigned i = 0; i < 4; i++) begin
            chk_beat("single", w1, i);
            tick();
        end
        chk("single_idle",  64'(out_valid_o),  64'd0);
        chk("single_cnt0",  64'(word_count_o), 64'd0);

        // Backpressure: beat advances only on ready cycles, data holds otherwise.
        w2             = 64'hFEDC_BA98_7654_3210;
        DataOut_i      = w2;
        DataOutReady_i = 1'b1;
        tick();
        DataOutReady_i = 1'b0;
        tick();
        pat = 7'b1101001;  // applied LSB first: 1,0,0,1,0,1,1
        b   = 0;
        for (int unsigned i = 0; i < 7; i++) begin
            chk_beat("bp", w2, b);
            out_ready_i = pat[i];
            tick();
            if (pat[i]) b++;
        end
        chk("bp_idle", 64'(out_valid_o),  64'd0);
        chk("bp_cnt0", 64'(word_count_o), 64'd0);

        // Fill with ready low; stall from count 6, 9th strobe overflows.
        out_ready_i = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            DataOut_i      = fill_word(k);
            DataOutReady_i = 1'b1;
            tick();
            chk("fill_cnt",   64'(word_count_o), 64'(k + 1));
            chk("fill_stall", 64'(seg_stall_o),  64'(k + 1 >= 6));
        end
        chk("fill_ovf0", 64'(overflow_o), 64'd0);
        DataOut_i = 64'hDEAD_BEEF_DEAD_BEEF;
        tick();
        DataOutReady_i = 1'b0;
        chk("fill_ovf1",  64'(overflow_o),   64'd1);
        chk("fill_cnt8",  64'(word_count_o), 64'd8);
        out_ready_i = 1'b1;
        for (int unsigned k = 0; k < 8; k++) begin
            for (int unsigned i = 0; i < 4; i++) begin
                chk_beat("drain", fill_word(k), i);
                tick();
            end
        end
        chk("drain_idle", 64'(out_valid_o),  64'd0);
        chk("drain_cnt0", 64'(word_count_o), 64'd0);
        chk("drain_nostall", 64'(seg_stall_o), 64'd0);

        // Simultaneous pop and strobe at full: strobe dropped, count 8 -> 7.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("sim_ovf_clr", 64'(overflow_o), 64'd0);
        out_ready_i = 1'b0;
        for (int unsigned k = 0; k < 8; k++) begin
            DataOut_i      = fill_word(k + 16);
            DataOutReady_i = 1'b1;
            tick();
        end
        DataOutReady_i = 1'b0;
        chk("sim_cnt8",  64'(word_count_o), 64'd8);
        chk("sim_ovf0",  64'(overflow_o),   64'd0);
        out_ready_i = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            chk_beat("sim_w0", fill_word(16), i);
            tick();
        end
        chk_beat("sim_w0", fill_word(16), 3);
        DataOut_i      = 64'hBAD0_BAD1_BAD2_BAD3;
        DataOutReady_i = 1'b1;
        tick();
        DataOutReady_i = 1'b0;
        chk("sim_ovf1", 64'(overflow_o),   64'd1);
        chk("sim_cnt7", 64'(word_count_o), 64'd7);
        for (int unsigned k = 1; k < 8; k++) begin
            for (int unsigned i = 0; i < 4; i++) begin
                chk_beat("sim_rest", fill_word(k + 16), i);
                tick();
            end
        end
        chk("sim_idle", 64'(out_valid_o), 64'd0);

        // Wrap-around: 20 words, each new strobe lands on the previous word's pop edge.
        DataOut_i      = 64'h1111;
        DataOutReady_i = 1'b1;
        tick();
        DataOutReady_i = 1'b0;
        chk("wrap_cnt_first", 64'(word_count_o), 64'd1);
        tick();
        for (int unsigned w = 1; w <= 20; w++) begin
            for (int unsigned i = 0; i < 4; i++) begin
                chk_beat("wrap", 64'(w) * 64'h1111, i);
                chk("wrap_cnt", 64'(word_count_o), 64'd1);
                if (i == 3 && w < 20) begin
                    DataOut_i      = 64'(w + 1) * 64'h1111;
                    DataOutReady_i = 1'b1;
                end else begin
                    DataOutReady_i = 1'b0;
                end
                tick();
            end
        end
        chk("wrap_idle", 64'(out_valid_o),  64'd0);
        chk("wrap_cnt0", 64'(word_count_o), 64'd0);
        chk("wrap_ovf_sticky", 64'(overflow_o), 64'd1);

        // Reset after beat 1 of a word discards it; the next word starts at beat 0.
        DataOut_i      = 64'h5555_6666_7777_8888;
        DataOutReady_i = 1'b1;
        tick();
        DataOutReady_i = 1'b0;
        tick();
        chk_beat("mid_b0", 64'h5555_6666_7777_8888, 0);
        tick();
        chk_beat("mid_b1", 64'h5555_6666_7777_8888, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_valid", 64'(out_valid_o),  64'd0);
        chk("mid_cnt",   64'(word_count_o), 64'd0);
        chk("mid_ovf",   64'(overflow_o),   64'd0);
        chk("mid_data",  64'(out_data_o),   64'd0);
        wz             = 64'h9A9A_0B0B_C1C1_D2D2;
        DataOut_i      = wz;
        DataOutReady_i = 1'b1;
        tick();
        DataOutReady_i = 1'b0;
        tick();
        for (int unsigned i = 0; i < 4; i++) begin
            chk_beat("post", wz, i);
            tick();
        end
        chk("post_idle", 64'(out_valid_o), 64'd0);
`ifdef SISP_OUT_PARITY_EN
        chk("par_err", 64'(parity_err_o), 64'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
